// File: rtl/alu_result_if.sv
// Handshake and lane bundle for the ALU result stage.
// master drives lanes and out_ready; slave is the result stage.
interface alu_result_if #(
    parameter int SIZE = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      ctrl_ALUopcode;
    logic [SIZE-1:0] data_operandA;
    logic [SIZE-1:0] data_operandB;
    logic [SIZE-1:0] or_result;
    logic [SIZE-1:0] and_result;
    logic [SIZE-1:0] sum_result;
    logic [SIZE-1:0] sll_result;
    logic [SIZE-1:0] sra_result;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] data_result;
    logic            isNotEqual;
    logic            isLessThan;
    logic            overflow;

    modport master (
        output in_valid, ctrl_ALUopcode, data_operandA, data_operandB,
        output or_result, and_result, sum_result, sll_result, sra_result,
        output out_ready,
        input  in_ready, out_valid, data_result, isNotEqual, isLessThan, overflow
    );

    modport slave (
        input  in_valid, ctrl_ALUopcode, data_operandA, data_operandB,
        input  or_result, and_result, sum_result, sll_result, sra_result,
        input  out_ready,
        output in_ready, out_valid, data_result, isNotEqual, isLessThan, overflow
    );
endinterface

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: opcode lane select, compare/overflow flags,
// and a 2-entry in-order valid/ready queue in front of the consumer.
module alu_result_stage #(
    parameter int SIZE  = 32,
    parameter int DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    alu_result_if.slave bus
);
    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;
    localparam logic [1:0] FULL   = 2'(DEPTH);

    logic [SIZE-1:0] sel_result;
    logic            sel_ne;
    logic            sel_lt;
    logic            sel_ov;
    logic            sign_s;
    logic            sign_a;
    logic            sign_b;

    assign sign_s = bus.sum_result[SIZE-1];
    assign sign_a = bus.data_operandA[SIZE-1];
    assign sign_b = bus.data_operandB[SIZE-1];

    always_comb begin
        sel_result = '0;
        sel_ne     = 1'b0;
        sel_lt     = 1'b0;
        sel_ov     = 1'b0;
        case (bus.ctrl_ALUopcode)
            OP_ADD: begin
                sel_result = bus.sum_result;
                sel_ov     = (sign_a == sign_b) && (sign_s != sign_a);
            end
            OP_SUB: begin
                sel_result = bus.sum_result;
                sel_ov     = (sign_a != sign_b) && (sign_s != sign_a);
                // sign of the difference corrected by overflow gives signed A<B
                sel_lt     = sign_s ^ sel_ov;
                sel_ne     = |bus.sum_result;
            end
            OP_AND:  sel_result = bus.and_result;
            OP_OR:   sel_result = bus.or_result;
            OP_SLL:  sel_result = bus.sll_result;
            OP_SRA:  sel_result = bus.sra_result;
            default: sel_result = '0;
        endcase
    end

    logic [SIZE-1:0] q_result [2];
    logic [2:0]      q_flags  [2];
    logic [1:0]      count;
    logic            head;
    logic            tail;
    logic            accept;
    logic            drain;

    assign bus.in_ready  = ~reset & (count != FULL);
    assign bus.out_valid = (count != 2'd0);
    assign accept        = bus.in_valid & bus.in_ready;
    assign drain         = bus.out_valid & bus.out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                q_result[i] <= '0;
                q_flags[i]  <= 3'b000;
            end
        end else begin
            if (accept) begin
                q_result[tail] <= sel_result;
                q_flags[tail]  <= {sel_ne, sel_lt, sel_ov};
                tail           <= ~tail;
            end
            if (drain) begin
                head <= ~head;
            end
            case ({accept, drain})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Drained slots are not scrubbed, so the head view is gated on occupancy.
    assign bus.data_result = bus.out_valid ? q_result[head] : '0;
    assign bus.isNotEqual  = bus.out_valid & q_flags[head][2];
    assign bus.isLessThan  = bus.out_valid & q_flags[head][1];
    assign bus.overflow    = bus.out_valid & q_flags[head][0];
endmodule
